// File: rtl/xor_serial_arbiter.sv
// Bit-serial XOR engine: two requesters share one four-NAND XOR cell
// under round-robin arbitration; results are assembled LSB-first.

module nand_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module xor_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n_ab;
  logic n_a;
  logic n_b;

  nand_cell u_n0 (.a(a), .b(b), .y(n_ab));
  nand_cell u_n1 (.a(a), .b(n_ab), .y(n_a));
  nand_cell u_n2 (.a(b), .b(n_ab), .y(n_b));
  nand_cell u_n3 (.a(n_a), .b(n_b), .y(y));
endmodule

module xor_serial_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_shift;
  logic [CW-1:0]    cnt;
  logic             id_q;
  logic             last_grant;
  logic             gnt0;
  logic             gnt1;
  logic             acc0;
  logic             acc1;
  logic             accept;
  logic             xbit;
  logic             last_bit;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        (req0_valid & req1_valid): begin
          gnt0 = last_grant;
          gnt1 = ~last_grant;
        end
        (req0_valid & ~req1_valid): gnt0 = 1'b1;
        (~req0_valid & req1_valid): gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc0       = req0_valid & gnt0;
  assign acc1       = req1_valid & gnt1;
  assign accept     = acc0 | acc1;

  xor_cell u_xor (
    .a(op_a[0]),
    .b(op_b[0]),
    .y(xbit)
  );

  // New bit enters at the MSB so LSB-first bits land in place.
  always_comb begin
    res_shift           = res_q >> 1;
    res_shift[WIDTH-1]  = xbit;
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_bit) state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      res_q      <= '0;
      cnt        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == IDLE && accept) begin
        op_a       <= acc1 ? req1_a : req0_a;
        op_b       <= acc1 ? req1_b : req0_b;
        cnt        <= '0;
        id_q       <= acc1;
        last_grant <= acc1;
      end
      if (state == RUN) begin
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        res_q <= res_shift;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  assign res_valid = (state == DONE);
  assign res_data  = res_q;
  assign res_id    = id_q;
  assign busy      = (state != IDLE);
endmodule

// File: doc/xor_serial_arbiter.md
Name: xor_serial_arbiter

Overview:
Bit-serial XOR engine that shares one gate-level 1-bit XOR cell (four NAND gates) between two requesters. A round-robin arbiter grants one requester at a time. A small FSM shifts the operands through the shared cell LSB-first and assembles the WIDTH-bit result. This block is the first sequential consumer of the gate-level XOR. It is also the template for later arbitrated, shared-ALU controllers in the Nandgame hardware tree.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
req0_valid  input  1  requester 0 has an operand pair.
req0_ready  output  1  requester 0 operands accepted this cycle when valid also high.
req0_a  input  WIDTH  requester 0 operand A.
req0_b  input  WIDTH  requester 0 operand B.
req1_valid  input  1  requester 1 has an operand pair.
req1_ready  output  1  requester 1 accept strobe.
req1_a  input  WIDTH  requester 1 operand A.
req1_b  input  WIDTH  requester 1 operand B.
res_valid  output  1  result available.
res_ready  input  1  consumer takes result.
res_data  output  WIDTH  a XOR b for the served request.
res_id  output  1  index of the requester whose result is on res_data.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; shift registers, bit counter, res_data and res_id cleared to 0.
  - res_valid=0 and busy=0.
  - Round-robin pointer last_grant=1, so requester 0 wins first after reset.
  - Any operation in flight is discarded and no result is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant is combinational and the ready outputs are driven only in IDLE.
  - If exactly one request is valid, that requester gets ready.
  - If both are valid, the requester != last_grant gets ready; the other gets 0.
  - Ready is never high for both requesters in the same cycle.
  - Accept = valid & ready. On the accept edge:
    - load op_a, op_b;
    - set cnt=0;
    - set res_id=granted index and last_grant=granted index;
    - go to RUN.
- RUN, one bit per cycle:
  - The shared XOR cell computes op_a[0] ^ op_b[0].
  - The result shift register takes the new bit at the MSB and shifts right.
  - op_a and op_b shift right; cnt increments.
  - On the edge where cnt==WIDTH-1, the last bit is captured and the state goes to DONE.
  - RUN lasts exactly WIDTH cycles. res_valid rises WIDTH clock edges after the accept edge.
- DONE:
  - res_valid=1; res_data and res_id stay stable until the handshake.
  - On res_valid & res_ready, go to IDLE on that edge and drop res_valid.
  - No new accept can occur in the handshake cycle (ready is only driven in IDLE).
  - Minimum throughput is one result per WIDTH+2 cycles.
- Requester rules: a/b must stay stable while valid is high and ready is low. The block samples operands only on the accept edge; later changes have no effect.
- Valid deasserting before grant is legal and results in no side effects.
- WIDTH=1: RUN lasts one cycle; cnt is still present (width max(1, clog2(WIDTH))).
- Only the shared gate-level XOR instance may produce result bits; the behavioural ^ operator is not used in the datapath.

Test Plan:
- WIDTH=8, after reset, req0 only, a=8'hA5, b=8'h3C: req0_ready=1 in the same cycle. res_valid rises 8 edges after the accept edge with res_data=8'h99, res_id=0. res_ready=1 returns the block to IDLE next edge with busy=0.
- Both valid together, req0 a=8'hFF b=8'h0F, req1 a=8'h12 b=8'h34: req0 is served first (res 8'hF0, id 0), then req1 (res 8'h26, id 1). req1 must not be ready while req0 is being served.
- Fairness: both valid continuously for 4 transactions → res_id sequence 0,1,0,1.
- Backpressure: result 8'h99 held with res_ready=0 for 5 cycles → res_valid, res_data and res_id unchanged, ready outputs 0. Release gives a single transfer.
- Reset mid-RUN: rst_n low 3 edges after an accept → outputs go to 0 immediately, without waiting for clk. After release, last_grant=1 and no stale result appears. A new req1-only request a=8'h00 b=8'hFF yields 8'hFF.
- WIDTH=1 instance: all four a/b combinations → res_data 0,1,1,0. res_valid rises 1 edge after each accept.
